// File: rtl/formal_dram_pkg.sv
// rtl/formal_dram_pkg.sv - shared types and command decoder for the formal DRAM responder
package formal_dram_pkg;

  typedef enum logic [2:0] {NOP, ACT, PRE, RD, WR, ILL} dram_cmd_e;
  typedef enum logic {IDLE, OPEN} dram_state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
  } rd_slot_t;

  localparam logic [3:0] WEN_NONE = 4'hF;

  // WEn doubles as the ACT/PRE and READ/WRITE discriminator: all-ones means no byte enabled.
  function automatic dram_cmd_e dram_decode(input logic csn, input logic rasn,
                                            input logic casn, input logic [3:0] wen);
    dram_cmd_e cmd;
    if (csn)                 cmd = NOP;
    else if (!rasn && !casn) cmd = ILL;
    else if (!rasn)          cmd = (wen == WEN_NONE) ? ACT : PRE;
    else if (!casn)          cmd = (wen == WEN_NONE) ? RD : WR;
    else                     cmd = NOP;
    return cmd;
  endfunction

endpackage

// File: rtl/formal_dram_array.sv
// rtl/formal_dram_array.sv - byte-writable 32-bit storage, async read, write on DRAM tick
module formal_dram_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 tick_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**ADDR_BITS];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (tick_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/formal_dram_model.sv
// rtl/formal_dram_model.sv - cycle-accurate DRAM responder closing the harness DRAM port
module formal_dram_model
  import formal_dram_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6,
  parameter int CAS_LAT  = 5,
  parameter int T_RCD    = 2
) (
  input  logic        top_clk,
  input  logic        top_rst,
  input  logic        dram_tick,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic        DRAM_valid,
  output logic [31:0] DRAM_Q,
  output logic        protocol_err
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int RCD_W     = $clog2(T_RCD + 2);

  dram_state_e          state_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [RCD_W-1:0]     rcd_q, rcd_d;
  rd_slot_t             pipe_q [CAS_LAT];
  dram_cmd_e            cmd_d;
  logic                 col_ok_d, do_rd_d, do_wr_d, err_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [3:0]           be_d;
  logic [31:0]          rdata;
  logic                 unused_a;

  assign unused_a = ^DRAM_A;

  // rcd_d is the number of DRAM edges since ACT as seen at this edge, so a
  // column command exactly T_RCD edges after ACT is accepted.
  always_comb begin
    cmd_d    = dram_decode(DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn);
    rcd_d    = (rcd_q == RCD_W'(T_RCD)) ? rcd_q : rcd_q + RCD_W'(1);
    col_ok_d = (state_q == OPEN) && (rcd_d == RCD_W'(T_RCD));
    do_rd_d  = (cmd_d == RD) && col_ok_d;
    do_wr_d  = (cmd_d == WR) && col_ok_d;
    err_d    = (cmd_d == ILL) || ((cmd_d == ACT) && (state_q == OPEN)) ||
               (((cmd_d == RD) || (cmd_d == WR)) && !col_ok_d);
    addr_d   = {row_q, DRAM_A[COL_BITS-1:0]};
    be_d     = do_wr_d ? ~DRAM_WEn : 4'b0000;
  end

  formal_dram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk_i   (top_clk),
    .tick_i  (dram_tick),
    .be_i    (be_d),
    .addr_i  (addr_d),
    .wdata_i (DRAM_D),
    .rdata_o (rdata)
  );

  always_ff @(posedge top_clk or posedge top_rst) begin
    if (top_rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      rcd_q        <= '0;
      DRAM_valid   <= 1'b0;
      DRAM_Q       <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < CAS_LAT; i++) pipe_q[i] <= '0;
    end else if (dram_tick) begin
      pipe_q[0] <= rd_slot_t'{vld: do_rd_d, data: do_rd_d ? rdata : 32'h0};
      for (int i = 1; i < CAS_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      DRAM_valid <= pipe_q[CAS_LAT-1].vld;
      if (pipe_q[CAS_LAT-1].vld) DRAM_Q <= pipe_q[CAS_LAT-1].data;
      if (err_d) protocol_err <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cmd_d == ACT) begin
            state_q <= OPEN;
            row_q   <= DRAM_A[ROW_BITS-1:0];
            rcd_q   <= '0;
          end
        end
        OPEN: begin
          rcd_q <= rcd_d;
          if (cmd_d == PRE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
